// File: rtl/eaglesong_pkg.sv
// Shared types and constants for the Eaglesong sponge blocks: state shape,
// rate width, squeeze FSM encoding and the output byte-mask helper.
package eaglesong_pkg;

   localparam int unsigned STATE_WORDS = 16;
   localparam int unsigned RATE_WORDS  = 8;
   localparam int unsigned LEN_W       = 7;

   typedef logic [STATE_WORDS-1:0][31:0] state_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      EMIT      = 2'd1,
      PERM_WAIT = 2'd2
   } squeeze_state_e;

   // Keeps the top nbytes bytes of a big-endian word (byte0 = bits [31:24]).
   function automatic logic [31:0] byte_mask(input logic [2:0] nbytes);
      logic [31:0] m;
      case (nbytes)
         3'd1:    m = 32'hFF00_0000;
         3'd2:    m = 32'hFFFF_0000;
         3'd3:    m = 32'hFFFF_FF00;
         3'd4:    m = 32'hFFFF_FFFF;
         default: m = 32'h0000_0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/eaglesong_squeeze_seq.sv
// Eaglesong squeeze sequencer: streams rate words of the sponge state as bytes,
// requesting an external permutation whenever a rate block runs out.
module eaglesong_squeeze_seq
   import eaglesong_pkg::*;
#(
   parameter int unsigned MAX_OUT_BYTES = 64,
   parameter int unsigned RATE_WORDS    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  state_t      state_in,
   input  logic [6:0]  output_length_bytes,
   input  logic        load_valid,
   output logic        load_ready,
   output logic        perm_req,
   output state_t      perm_state_out,
   input  logic        perm_ack,
   input  state_t      perm_state_in,
   output logic [31:0] out_word,
   output logic [2:0]  out_nbytes,
   output logic        out_last,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int unsigned IDX_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
   localparam int unsigned SEL_W = $clog2(STATE_WORDS);
   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_OUT_BYTES);
   localparam logic [LEN_W-1:0] WORD_LEN = LEN_W'(4);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_WORDS - 1);

   squeeze_state_e   fsm_q, fsm_d;
   state_t           state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             load_ready_q, load_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             perm_req_q, perm_req_d;

   logic [LEN_W-1:0] req_len;
   logic [LEN_W-1:0] rem_after;
   logic [2:0]       cur_nbytes;
   logic [SEL_W-1:0] word_sel;
   logic [31:0]      cur_word;

   function automatic logic [LEN_W-1:0] clip_len(input logic [LEN_W-1:0] len);
      return (len > MAX_LEN) ? MAX_LEN : len;
   endfunction

   // Output word view: everything derives from registered state and counters.
   always_comb begin
      cur_nbytes = (rem_q >= WORD_LEN) ? 3'd4 : rem_q[2:0];
      word_sel   = SEL_W'(idx_q);
      cur_word   = state_q[word_sel] & byte_mask(cur_nbytes);
      rem_after  = rem_q - LEN_W'(cur_nbytes);
      req_len    = clip_len(output_length_bytes);
   end

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      rem_d   = rem_q;
      idx_d   = idx_q;

      unique case (fsm_q)
         IDLE: begin
            if (load_valid && load_ready_q) begin
               state_d = state_in;
               rem_d   = req_len;
               idx_d   = '0;
               // A zero-length request is consumed without ever leaving IDLE.
               if (req_len != '0) begin
                  fsm_d = EMIT;
               end
            end
         end
         EMIT: begin
            if (out_valid_q && out_ready) begin
               rem_d = rem_after;
               // Finishing takes priority so the last word never asks for a permutation.
               if (rem_after == '0) begin
                  fsm_d = IDLE;
               end else if (idx_q == LAST_IDX) begin
                  fsm_d = PERM_WAIT;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         PERM_WAIT: begin
            if (perm_ack) begin
               state_d = perm_state_in;
               idx_d   = '0;
               fsm_d   = EMIT;
            end
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase

      load_ready_d = (fsm_d == IDLE);
      out_valid_d  = (fsm_d == EMIT);
      perm_req_d   = (fsm_d == PERM_WAIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q        <= IDLE;
         state_q      <= '0;
         rem_q        <= '0;
         idx_q        <= '0;
         load_ready_q <= 1'b1;
         out_valid_q  <= 1'b0;
         perm_req_q   <= 1'b0;
      end else begin
         fsm_q        <= fsm_d;
         state_q      <= state_d;
         rem_q        <= rem_d;
         idx_q        <= idx_d;
         load_ready_q <= load_ready_d;
         out_valid_q  <= out_valid_d;
         perm_req_q   <= perm_req_d;
      end
   end

   // Data outputs are forced to zero whenever no word is being offered.
   always_comb begin
      load_ready     = load_ready_q;
      out_valid      = out_valid_q;
      perm_req       = perm_req_q;
      perm_state_out = state_q;
      out_word       = out_valid_q ? cur_word : 32'h0;
      out_nbytes     = out_valid_q ? cur_nbytes : 3'd0;
      out_last       = out_valid_q && (rem_q <= WORD_LEN);
   end

endmodule
